// File: rtl/load_store_unit_if.sv
// Data-memory request/response channel between the load/store unit and memory.
//   dmem_req_valid  : request valid (LSU -> mem)
//   dmem_req_ready  : memory accepts the request (mem -> LSU)
//   dmem_req_addr   : word-aligned address
//   dmem_req_we     : 1 = write
//   dmem_req_be     : byte enables
//   dmem_req_wdata  : lane-replicated store data
//   dmem_rsp_valid  : read data valid (mem -> LSU)
//   dmem_rsp_rdata  : read word
interface load_store_unit_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_req_addr;
  logic        dmem_req_we;
  logic [3:0]  dmem_req_be;
  logic [31:0] dmem_req_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;

  modport master (
    output dmem_req_valid,
    input  dmem_req_ready,
    output dmem_req_addr,
    output dmem_req_we,
    output dmem_req_be,
    output dmem_req_wdata,
    input  dmem_rsp_valid,
    input  dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid,
    output dmem_req_ready,
    input  dmem_req_addr,
    input  dmem_req_we,
    input  dmem_req_be,
    input  dmem_req_wdata,
    output dmem_rsp_valid,
    output dmem_rsp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-access stage. Takes the ALU result as effective address, issues one
// data-memory request per load/store, aligns and extends load data, and stalls the
// upstream pipeline until the access completes, faults, or times out.
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_ex_*               : operation presented by the execute stage
//   o_stall              : hold upstream stages
//   o_wb_valid           : one-cycle completion pulse
//   o_wb_load_data       : extended load result (held until the next load completes)
//   o_misaligned         : one-cycle fault pulse (misaligned or reserved funct3)
//   o_bus_error          : one-cycle timeout pulse
//   dmem                 : request/response channel (master side)
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ex_valid,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_mem_write,
  input  logic [2:0]        i_ex_funct3,
  input  logic [31:0]       i_ex_address,
  input  logic [31:0]       i_ex_store_data,
  output logic              o_stall,
  output logic              o_wb_valid,
  output logic [31:0]       o_wb_load_data,
  output logic              o_misaligned,
  output logic              o_bus_error,
  load_store_unit_if.master dmem
);

  // Counter only needs to hold 0 .. TIMEOUT_CYCLES-1.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e          r_state;
  logic [31:0]     r_addr;
  logic [2:0]      r_funct3;
  logic            r_we;
  logic [3:0]      r_be;
  logic [31:0]     r_wdata;
  logic            r_req_valid;
  logic            r_wb_valid;
  logic [31:0]     r_wb_load_data;
  logic            r_misaligned;
  logic            r_bus_error;
  logic [CntW-1:0] r_cnt;

  logic        w_idle_op;
  logic        w_legal;
  logic        w_aligned;
  logic        w_accept;
  logic        w_fault;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  always_comb begin
    w_idle_op = (r_state == StIdle) & i_ex_valid & (i_ex_mem_read | i_ex_mem_write);

    // Read wins when both read and write are set.
    if (i_ex_mem_read) begin
      w_legal = (i_ex_funct3[1:0] != 2'b11) & ~(i_ex_funct3[2] & i_ex_funct3[1]);
    end else begin
      w_legal = ~i_ex_funct3[2] & (i_ex_funct3[1:0] != 2'b11);
    end

    case (i_ex_funct3[1:0])
      2'b01:   w_aligned = ~i_ex_address[0];
      2'b10:   w_aligned = (i_ex_address[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase

    w_accept = w_idle_op & w_legal & w_aligned;
    w_fault  = w_idle_op & ~(w_legal & w_aligned);

    // Store formatting: replicate data across lanes, enable only the addressed bytes.
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (!i_ex_mem_read) begin
      case (i_ex_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << i_ex_address[1:0];
          w_wdata = {4{i_ex_store_data[7:0]}};
        end
        2'b01: begin
          w_be    = i_ex_address[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{i_ex_store_data[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = i_ex_store_data;
        end
      endcase
    end

    // Load extraction from the captured address/funct3.
    case (r_addr[1:0])
      2'b00:   w_byte = dmem.dmem_rsp_rdata[7:0];
      2'b01:   w_byte = dmem.dmem_rsp_rdata[15:8];
      2'b10:   w_byte = dmem.dmem_rsp_rdata[23:16];
      default: w_byte = dmem.dmem_rsp_rdata[31:24];
    endcase
    w_half = r_addr[1] ? dmem.dmem_rsp_rdata[31:16] : dmem.dmem_rsp_rdata[15:0];

    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = dmem.dmem_rsp_rdata;
    endcase

    w_timeout = (TIMEOUT_CYCLES != 32'd0) && (r_cnt == CntLast);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_addr         <= 32'h0;
      r_funct3       <= 3'b000;
      r_we           <= 1'b0;
      r_be           <= 4'b0000;
      r_wdata        <= 32'h0;
      r_req_valid    <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_load_data <= 32'h0;
      r_misaligned   <= 1'b0;
      r_bus_error    <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_misaligned <= w_fault;
      r_bus_error  <= 1'b0;
      r_wb_valid   <= 1'b0;
      case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (w_accept) begin
            r_addr      <= i_ex_address;
            r_funct3    <= i_ex_funct3;
            r_we        <= ~i_ex_mem_read;
            r_be        <= w_be;
            r_wdata     <= w_wdata;
            r_req_valid <= 1'b1;
            r_state     <= StReq;
          end
        end
        StReq: begin
          // A handshake in the same cycle as the timeout still completes the access.
          if (dmem.dmem_req_ready) begin
            r_req_valid <= 1'b0;
            if (r_we) begin
              r_state    <= StDone;
              r_wb_valid <= 1'b1;
              r_cnt      <= '0;
            end else begin
              r_state <= StWait;
              // Saturate so the first idle WAIT cycle times out instead of wrapping.
              if (!w_timeout) r_cnt <= r_cnt + CntW'(1);
            end
          end else if (w_timeout) begin
            r_req_valid <= 1'b0;
            r_bus_error <= 1'b1;
            r_state     <= StIdle;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StWait: begin
          if (dmem.dmem_rsp_valid) begin
            r_wb_load_data <= w_load;
            r_wb_valid     <= 1'b1;
            r_state        <= StDone;
            r_cnt          <= '0;
          end else if (w_timeout) begin
            r_bus_error <= 1'b1;
            r_state     <= StIdle;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDone: begin
          // The op still presented upstream this cycle is the one just completed.
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Combinational so upstream already holds during the accept cycle.
  assign o_stall = ~i_reset & (w_accept | (r_state == StReq) | (r_state == StWait));

  assign o_wb_valid          = r_wb_valid;
  assign o_wb_load_data      = r_wb_load_data;
  assign o_misaligned        = r_misaligned;
  assign o_bus_error         = r_bus_error;
  assign dmem.dmem_req_valid = r_req_valid;
  assign dmem.dmem_req_addr  = {r_addr[31:2], 2'b00};
  assign dmem.dmem_req_we    = r_we;
  assign dmem.dmem_req_be    = r_be;
  assign dmem.dmem_req_wdata = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a table of single-op vectors with
// hand-computed request fields and load results, plus directed sequences for
// delayed ready, fault-then-accept, timeout and reset in WAIT.
module tb_load_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ex_valid, ex_rd, ex_wr;
  logic [2:0]  ex_f3;
  logic [31:0] ex_addr, ex_sdata;
  logic        stall, wb_valid, misaligned, bus_error;
  logic [31:0] wb_data;

  logic        to_ex_valid;
  logic        to_stall, to_wb_valid, to_mis, to_berr;
  logic [31:0] to_wb_data;

  load_store_unit_if mem_if ();
  load_store_unit_if to_if ();

  load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
    .i_clk(clk), .i_reset(reset), .i_ex_valid(ex_valid), .i_ex_mem_read(ex_rd),
    .i_ex_mem_write(ex_wr), .i_ex_funct3(ex_f3), .i_ex_address(ex_addr),
    .i_ex_store_data(ex_sdata), .o_stall(stall), .o_wb_valid(wb_valid),
    .o_wb_load_data(wb_data), .o_misaligned(misaligned), .o_bus_error(bus_error),
    .dmem(mem_if.master)
  );

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .i_clk(clk), .i_reset(reset), .i_ex_valid(to_ex_valid), .i_ex_mem_read(ex_rd),
    .i_ex_mem_write(ex_wr), .i_ex_funct3(ex_f3), .i_ex_address(ex_addr),
    .i_ex_store_data(ex_sdata), .o_stall(to_stall), .o_wb_valid(to_wb_valid),
    .o_wb_load_data(to_wb_data), .o_misaligned(to_mis), .o_bus_error(to_berr),
    .dmem(to_if.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  // Observations from the last run_op window (cycle 0 = cycle the op is presented).
  int          obs_wb_cnt, obs_wb_cyc, obs_mis_cnt, obs_mis_cyc, obs_req_cnt, obs_req_first;
  int          obs_berr_cnt;
  logic [31:0] obs_wb_data, obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we, obs_unstable;
  logic [7:0]  obs_stall;

  // Presents one op and plays a memory that raises ready after ready_delay request
  // cycles and returns rdata the cycle after a load handshake. Upstream holds the op
  // until the end of the first cycle with stall low.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] rdata, input int ready_delay);
    logic hold;
    logic hs;
    int   req_seen;
    obs_wb_cnt = 0; obs_wb_cyc = -1; obs_mis_cnt = 0; obs_mis_cyc = -1;
    obs_req_first = -1; obs_berr_cnt = 0; obs_unstable = 1'b0; obs_stall = 8'h00;
    obs_wb_data = 32'h0; obs_addr = 32'h0; obs_wdata = 32'h0; obs_be = 4'h0; obs_we = 1'b0;
    ex_valid = 1'b1; ex_rd = rd; ex_wr = wr; ex_f3 = f3; ex_addr = addr; ex_sdata = sdata;
    mem_if.dmem_req_ready = (ready_delay == 0);
    mem_if.dmem_rsp_valid = 1'b0;
    mem_if.dmem_rsp_rdata = rdata;
    hold = 1'b1;
    req_seen = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      obs_stall[3'(c)] = stall;
      if (wb_valid) begin
        obs_wb_cnt++;
        if (obs_wb_cnt == 1) begin
          obs_wb_cyc  = c;
          obs_wb_data = wb_data;
        end
      end
      if (misaligned) begin
        obs_mis_cnt++;
        obs_mis_cyc = c;
      end
      if (bus_error) obs_berr_cnt++;
      if (mem_if.dmem_req_valid) begin
        if (req_seen == 0) begin
          obs_req_first = c;
          obs_addr  = mem_if.dmem_req_addr;
          obs_be    = mem_if.dmem_req_be;
          obs_we    = mem_if.dmem_req_we;
          obs_wdata = mem_if.dmem_req_wdata;
        end else if (obs_addr != mem_if.dmem_req_addr || obs_be != mem_if.dmem_req_be ||
                     obs_we != mem_if.dmem_req_we || obs_wdata != mem_if.dmem_req_wdata) begin
          obs_unstable = 1'b1;
        end
        req_seen++;
      end
      hs = mem_if.dmem_req_valid & mem_if.dmem_req_ready;
      if (!stall) hold = 1'b0;
      step();
      ex_valid = hold;
      mem_if.dmem_rsp_valid = hs & rd;
      mem_if.dmem_req_ready = (req_seen >= ready_delay);
    end
    obs_req_cnt = req_seen;
    ex_valid = 1'b0;
    mem_if.dmem_req_ready = 1'b0;
    mem_if.dmem_rsp_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] last_load;
    logic [8:0]  to_req_mask, to_berr_mask, to_stall_mask;
    int          to_wb_cnt;
    int          wbc;

    vecs[0]  = '{"LW 1008",   1, 0, 3'b010, 32'h1008, 32'h0, 32'hDEADBEEF,
                 0, 32'h1008, 4'hF, 0, 32'h0, 32'hDEADBEEF};
    vecs[1]  = '{"LB 1003",   1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF0102,
                 0, 32'h1000, 4'hF, 0, 32'h0, 32'hFFFFFF80};
    vecs[2]  = '{"LBU 1003",  1, 0, 3'b100, 32'h1003, 32'h0, 32'h80FF0102,
                 0, 32'h1000, 4'hF, 0, 32'h0, 32'h00000080};
    vecs[3]  = '{"LHU 1002",  1, 0, 3'b101, 32'h1002, 32'h0, 32'h80FF0102,
                 0, 32'h1000, 4'hF, 0, 32'h0, 32'h000080FF};
    vecs[4]  = '{"LH 1002",   1, 0, 3'b001, 32'h1002, 32'h0, 32'h80FF0102,
                 0, 32'h1000, 4'hF, 0, 32'h0, 32'hFFFF80FF};
    vecs[5]  = '{"LB 1001",   1, 0, 3'b000, 32'h1001, 32'h0, 32'h80FF0102,
                 0, 32'h1000, 4'hF, 0, 32'h0, 32'h00000001};
    vecs[6]  = '{"LH 1000",   1, 0, 3'b001, 32'h1000, 32'h0, 32'h1234F00D,
                 0, 32'h1000, 4'hF, 0, 32'h0, 32'hFFFFF00D};
    vecs[7]  = '{"LBU 1000",  1, 0, 3'b100, 32'h1000, 32'h0, 32'h000000F0,
                 0, 32'h1000, 4'hF, 0, 32'h0, 32'h000000F0};
    vecs[8]  = '{"SB 2001",   0, 1, 3'b000, 32'h2001, 32'h123456A5, 32'h0,
                 0, 32'h2000, 4'b0010, 1, 32'hA5A5A5A5, 32'h0};
    vecs[9]  = '{"SB 2003",   0, 1, 3'b000, 32'h2003, 32'h00000077, 32'h0,
                 0, 32'h2000, 4'b1000, 1, 32'h77777777, 32'h0};
    vecs[10] = '{"SH 2000",   0, 1, 3'b001, 32'h2000, 32'hCAFEBEEF, 32'h0,
                 0, 32'h2000, 4'b0011, 1, 32'hBEEFBEEF, 32'h0};
    vecs[11] = '{"SW 2004",   0, 1, 3'b010, 32'h2004, 32'h0BADF00D, 32'h0,
                 0, 32'h2004, 4'b1111, 1, 32'h0BADF00D, 32'h0};
    vecs[12] = '{"LW 3001",   1, 0, 3'b010, 32'h3001, 32'h0, 32'h0,
                 1, 32'h0, 4'h0, 0, 32'h0, 32'h0};
    vecs[13] = '{"LH 3003",   1, 0, 3'b001, 32'h3003, 32'h0, 32'h0,
                 1, 32'h0, 4'h0, 0, 32'h0, 32'h0};
    vecs[14] = '{"SW 3002",   0, 1, 3'b010, 32'h3002, 32'h0, 32'h0,
                 1, 32'h0, 4'h0, 0, 32'h0, 32'h0};
    vecs[15] = '{"SH 3001",   0, 1, 3'b001, 32'h3001, 32'h0, 32'h0,
                 1, 32'h0, 4'h0, 0, 32'h0, 32'h0};
    vecs[16] = '{"LD f3=011", 1, 0, 3'b011, 32'h3000, 32'h0, 32'h0,
                 1, 32'h0, 4'h0, 0, 32'h0, 32'h0};
    vecs[17] = '{"ST f3=100", 0, 1, 3'b100, 32'h3000, 32'h0, 32'h0,
                 1, 32'h0, 4'h0, 0, 32'h0, 32'h0};
    vecs[18] = '{"LD f3=110", 1, 0, 3'b110, 32'h3000, 32'h0, 32'h0,
                 1, 32'h0, 4'h0, 0, 32'h0, 32'h0};
    vecs[19] = '{"RD+WR 1010", 1, 1, 3'b010, 32'h1010, 32'h55555555, 32'h13579BDF,
                 0, 32'h1010, 4'hF, 0, 32'h0, 32'h13579BDF};
    vecs[20] = '{"LB 3001",   1, 0, 3'b000, 32'h3001, 32'h0, 32'h00FF7F00,
                 0, 32'h3000, 4'hF, 0, 32'h0, 32'h0000007F};
    vecs[21] = '{"SB 2000",   0, 1, 3'b000, 32'h2000, 32'h000000C3, 32'h0,
                 0, 32'h2000, 4'b0001, 1, 32'hC3C3C3C3, 32'h0};

    // Reset, with a stale response present that must be ignored.
    reset = 1'b1;
    ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0; ex_f3 = 3'b000;
    ex_addr = 32'h0; ex_sdata = 32'h0; to_ex_valid = 1'b0;
    mem_if.dmem_req_ready = 1'b0; mem_if.dmem_rsp_valid = 1'b1;
    mem_if.dmem_rsp_rdata = 32'hFFFFFFFF;
    to_if.dmem_req_ready = 1'b0; to_if.dmem_rsp_valid = 1'b0; to_if.dmem_rsp_rdata = 32'h0;
    repeat (3) step();
    reset = 1'b0;
    #1;
    check("reset stall", 32'(stall), 32'd0);
    check("reset wb_valid", 32'(wb_valid), 32'd0);
    check("reset wb_load_data", wb_data, 32'h0);
    check("reset misaligned", 32'(misaligned), 32'd0);
    check("reset bus_error", 32'(bus_error), 32'd0);
    check("reset req_valid", 32'(mem_if.dmem_req_valid), 32'd0);
    check("reset req_addr", mem_if.dmem_req_addr, 32'h0);
    check("reset req_be", 32'(mem_if.dmem_req_be), 32'd0);
    check("reset req_we", 32'(mem_if.dmem_req_we), 32'd0);
    check("reset req_wdata", mem_if.dmem_req_wdata, 32'h0);
    step();
    check("stale rsp wb_valid", 32'(wb_valid), 32'd0);
    check("stale rsp wb_load_data", wb_data, 32'h0);
    mem_if.dmem_rsp_valid = 1'b0;
    step();

    // Table-driven single ops with zero-wait memory.
    last_load = 32'h0;
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].sdata,
             vecs[i].rdata, 0);
      if (vecs[i].exp_mis) begin
        check($sformatf("%s mis count", vecs[i].name), 32'(obs_mis_cnt), 32'd1);
        check($sformatf("%s mis cycle", vecs[i].name), 32'(obs_mis_cyc), 32'd1);
        check($sformatf("%s req count", vecs[i].name), 32'(obs_req_cnt), 32'd0);
        check($sformatf("%s wb count", vecs[i].name), 32'(obs_wb_cnt), 32'd0);
        check($sformatf("%s stall", vecs[i].name), 32'(obs_stall), 32'd0);
      end else begin
        wbc = vecs[i].rd ? 3 : 2;
        check($sformatf("%s mis count", vecs[i].name), 32'(obs_mis_cnt), 32'd0);
        check($sformatf("%s req first", vecs[i].name), 32'(obs_req_first), 32'd1);
        check($sformatf("%s req addr", vecs[i].name), obs_addr, vecs[i].exp_addr);
        check($sformatf("%s req be", vecs[i].name), 32'(obs_be), 32'(vecs[i].exp_be));
        check($sformatf("%s req we", vecs[i].name), 32'(obs_we), 32'(vecs[i].exp_we));
        if (vecs[i].wr && !vecs[i].rd) begin
          check($sformatf("%s req wdata", vecs[i].name), obs_wdata, vecs[i].exp_wdata);
        end
        check($sformatf("%s wb count", vecs[i].name), 32'(obs_wb_cnt), 32'd1);
        check($sformatf("%s wb cycle", vecs[i].name), 32'(obs_wb_cyc), 32'(wbc));
        check($sformatf("%s stall", vecs[i].name), 32'(obs_stall), 32'((1 << wbc) - 1));
        if (vecs[i].rd) last_load = vecs[i].exp_load;
        check($sformatf("%s wb_load_data", vecs[i].name), obs_wb_data, last_load);
      end
      check($sformatf("%s bus_error", vecs[i].name), 32'(obs_berr_cnt), 32'd0);
    end

    // SH with ready delayed by 3 request cycles: fields stable, wb one cycle after handshake.
    run_op(1'b0, 1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 32'h0, 3);
    check("SH delay addr", obs_addr, 32'h2000);
    check("SH delay be", 32'(obs_be), 32'hC);
    check("SH delay wdata", obs_wdata, 32'hABCDABCD);
    check("SH delay we", 32'(obs_we), 32'd1);
    check("SH delay stable", 32'(obs_unstable), 32'd0);
    check("SH delay req cycles", 32'(obs_req_cnt), 32'd4);
    check("SH delay wb cycle", 32'(obs_wb_cyc), 32'd5);
    check("SH delay wb count", 32'(obs_wb_cnt), 32'd1);
    check("SH delay stall", 32'(obs_stall), 32'h1F);

    // Misaligned LW followed directly by an aligned SW.
    mem_if.dmem_req_ready = 1'b1;
    ex_valid = 1'b1; ex_rd = 1'b1; ex_wr = 1'b0; ex_f3 = 3'b010; ex_addr = 32'h3001;
    #1;
    check("mis seq c0 stall", 32'(stall), 32'd0);
    step();
    ex_rd = 1'b0; ex_wr = 1'b1; ex_addr = 32'h3004; ex_sdata = 32'h55AA55AA;
    #1;
    check("mis seq c1 misaligned", 32'(misaligned), 32'd1);
    check("mis seq c1 stall", 32'(stall), 32'd1);
    check("mis seq c1 req_valid", 32'(mem_if.dmem_req_valid), 32'd0);
    step();
    check("mis seq c2 misaligned", 32'(misaligned), 32'd0);
    check("mis seq c2 req_valid", 32'(mem_if.dmem_req_valid), 32'd1);
    check("mis seq c2 addr", mem_if.dmem_req_addr, 32'h3004);
    check("mis seq c2 be", 32'(mem_if.dmem_req_be), 32'hF);
    check("mis seq c2 wdata", mem_if.dmem_req_wdata, 32'h55AA55AA);
    step();
    #1;
    check("mis seq c3 wb_valid", 32'(wb_valid), 32'd1);
    check("mis seq c3 stall", 32'(stall), 32'd0);
    step();
    ex_valid = 1'b0;
    #1;
    check("mis seq c4 wb_valid", 32'(wb_valid), 32'd0);
    check("mis seq c4 req_valid", 32'(mem_if.dmem_req_valid), 32'd0);
    mem_if.dmem_req_ready = 1'b0;
    step();

    // Timeout on the TIMEOUT_CYCLES=4 instance with ready held low.
    ex_rd = 1'b1; ex_wr = 1'b0; ex_f3 = 3'b010; ex_addr = 32'h1008;
    to_ex_valid = 1'b1;
    to_req_mask = '0; to_berr_mask = '0; to_stall_mask = '0; to_wb_cnt = 0;
    for (int c = 0; c < 9; c++) begin
      #1;
      to_req_mask[4'(c)]   = to_if.dmem_req_valid;
      to_berr_mask[4'(c)]  = to_berr;
      to_stall_mask[4'(c)] = to_stall;
      if (to_wb_valid) to_wb_cnt++;
      step();
      to_ex_valid = 1'b0;
    end
    check("timeout req_valid cycles", 32'(to_req_mask), 32'h01E);
    check("timeout bus_error cycles", 32'(to_berr_mask), 32'h020);
    check("timeout stall cycles", 32'(to_stall_mask), 32'h01F);
    check("timeout wb count", 32'(to_wb_cnt), 32'd0);
    to_ex_valid = 1'b1;
    #1;
    check("timeout idle accept stall", 32'(to_stall), 32'd1);
    step();
    to_ex_valid = 1'b0;
    check("timeout idle accept req", 32'(to_if.dmem_req_valid), 32'd1);
    repeat (6) step();

    // Reset while waiting for a load response, then a stale response after reset.
    mem_if.dmem_req_ready = 1'b1;
    ex_valid = 1'b1; ex_rd = 1'b1; ex_wr = 1'b0; ex_f3 = 3'b010; ex_addr = 32'h1008;
    step();
    step();
    check("rst-wait in WAIT stall", 32'(stall), 32'd1);
    check("rst-wait in WAIT req_valid", 32'(mem_if.dmem_req_valid), 32'd0);
    reset = 1'b1;
    ex_valid = 1'b0;
    step();
    reset = 1'b0;
    mem_if.dmem_rsp_valid = 1'b1;
    mem_if.dmem_rsp_rdata = 32'h12345678;
    #1;
    check("rst-wait stall", 32'(stall), 32'd0);
    check("rst-wait wb_valid", 32'(wb_valid), 32'd0);
    check("rst-wait wb_load_data", wb_data, 32'h0);
    check("rst-wait req_valid", 32'(mem_if.dmem_req_valid), 32'd0);
    check("rst-wait req_be", 32'(mem_if.dmem_req_be), 32'd0);
    check("rst-wait req_addr", mem_if.dmem_req_addr, 32'h0);
    step();
    check("rst-wait stale wb_valid", 32'(wb_valid), 32'd0);
    check("rst-wait stale wb_load_data", wb_data, 32'h0);
    mem_if.dmem_rsp_valid = 1'b0;
    mem_if.dmem_req_ready = 1'b0;
    step();
    run_op(1'b1, 1'b0, 3'b010, 32'h1008, 32'h0, 32'h0F0F0F0F, 0);
    check("post-reset LW wb cycle", 32'(obs_wb_cyc), 32'd3);
    check("post-reset LW wb_load_data", obs_wb_data, 32'h0F0F0F0F);
    check("post-reset LW req addr", obs_addr, 32'h1008);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the RV32I pipeline.
- Takes the ALU result as the effective address, plus the rs2 store data and funct3.
- Drives a valid/ready data-memory request channel and waits for the read response.
- Aligns and sign/zero-extends load data, and stalls the upstream pipeline until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: cycles allowed in REQ+WAIT before aborting with bus_error; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  execute stage presents an instruction
- ex_mem_read  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store
- ex_funct3  in  3  RV32I load/store funct3
- ex_address  in  32  effective address (ALU result)
- ex_store_data  in  32  rs2 value
- stall  out  1  hold upstream stages
- wb_valid  out  1  one-cycle completion pulse
- wb_load_data  out  32  extended load result, valid when wb_valid=1 and the op was a load
- misaligned  out  1  one-cycle fault pulse
- bus_error  out  1  one-cycle timeout pulse
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_addr  out  32  word address {addr[31:2],2'b00}
- dmem_req_we  out  1  1=write
- dmem_req_be  out  4  byte enables
- dmem_req_wdata  out  32  lane-replicated store data
- dmem_rsp_valid  in  1  read data valid
- dmem_rsp_rdata  in  32  read word

Behaviour:
- Reset: state IDLE, timeout counter 0. All outputs 0: stall, wb_valid, wb_load_data, misaligned, bus_error, dmem_req_*.
- States: IDLE, REQ, WAIT, DONE.
- Accept condition: state IDLE, ex_valid=1, (ex_mem_read|ex_mem_write)=1, and the op is legal and aligned.
  - ex_mem_read takes priority if both read and write are set.
  - stall = accept | (state==REQ) | (state==WAIT). It is combinational, so upstream holds during the accept cycle.
- Accept captures address, funct3, rd/wr and formatted store data into registers, then goes to REQ. No request goes out in the accept cycle.
- REQ:
  - dmem_req_valid=1; addr/we/be/wdata come from registers and stay stable until the handshake.
  - On dmem_req_ready: store goes to DONE; load goes to WAIT.
- WAIT:
  - On dmem_rsp_valid, capture the extracted lane into wb_load_data and go to DONE.
  - Extraction: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW takes the full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- DONE: wb_valid=1, stall=0, go to IDLE. No new accept in DONE, because the upstream op still present that cycle is the completed one.
- Latency: accept in cycle N gives the request in N+1. With zero-wait memory, a store completes with wb_valid at N+2. A load with the response in the cycle after the handshake has wb_valid at N+3.
- Store formatting:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111, wdata=rs2.
  - Loads: be=4'b1111, we=0.
- Misaligned fault: IDLE with a valid op where any of the following holds:
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - reserved funct3 (load 011/110/111; store 011–111)
- On a misaligned fault: no request is issued, stall=0, and misaligned pulses high in the next cycle for exactly 1 cycle. State stays IDLE.
- Timeout:
  - The counter increments each cycle in REQ/WAIT and clears on leaving them.
  - When it reaches TIMEOUT_CYCLES, drop dmem_req_valid, pulse bus_error for 1 cycle, go to IDLE, and drop stall.
  - wb_valid is not asserted on timeout.
- dmem_rsp_valid outside WAIT is ignored, including stale responses after reset.
- Reset mid-operation returns to IDLE in the same edge and drops dmem_req_valid.
- wb_load_data holds its value until the next load completes.

Test Plan:
- LW at 0x0000_1008, ready=1 immediately, rdata=0xDEAD_BEEF one cycle after handshake:
  - dmem_req_addr=0x1008, be=1111, we=0
  - wb_valid at N+3, wb_load_data=0xDEADBEEF
  - stall high N..N+2
- LB at 0x1003 with rdata=0x80FF_0102 → 0xFFFF_FF80. LBU at the same address → 0x0000_0080. LHU at 0x1002 → 0x0000_80FF.
- SH at 0x2002 with rs2=0x1234_ABCD, ready delayed 3 cycles:
  - req fields held stable throughout: addr=0x2000, be=1100, wdata=0xABCD_ABCD, we=1
  - wb_valid one cycle after the handshake
- LW at 0x3001: no dmem_req_valid, stall=0, misaligned=1 for exactly one cycle. SW at 0x3004 on the following cycle is accepted normally.
- TIMEOUT_CYCLES=4, load with ready held 0: bus_error pulses after 4 REQ cycles, wb_valid stays 0, state returns to IDLE.
- reset asserted in WAIT, then dmem_rsp_valid=1 after reset: all outputs 0, no wb_valid, next LW completes normally.
